am2302_bcd_decoder: RTL and testbench

Downstream consumer of the AM2302 single-wire master's 5-byte frame. Accepts the 40-bit frame as one pulse-qualified word and verifies the checksum and value range. It then converts humidity and temperature (tenths, sign-magnitude) to packed 4-digit BCD with a sequential shift-add-3 (double-dabble) engine. Results feed the display/SFR readout logic.

---
 rtl/am2302_bcd_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_am2302_bcd_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/am2302_bcd_decoder.sv
// -----------------------------------------------------------------------------
// am2302_bcd_decoder
//
// Purpose:
//    Takes the 5-byte AM2302 frame from the single-wire master in one strobe.
//    It checks the checksum and the value range, and then converts humidity
//    and temperature magnitude into packed 4-digit BCD (tenths). The BCD
//    conversion is a sequential shift-add-3 (double-dabble) engine that
//    handles one bit per cycle.
//
// Ports:
//    clk           system clock
//    rst_n         asynchronous active-low reset
//    frame_valid   one-cycle strobe, frame_data is valid in that cycle
//    frame_data    {RH hi, RH lo, T hi, T lo, checksum}
//    busy          high whenever the FSM is not IDLE
//    result_valid  one-cycle pulse, new status (and digits if good) ready
//    hum_bcd       humidity, 4 BCD digits, tenths
//    temp_bcd      temperature magnitude, 4 BCD digits, tenths
//    temp_neg      temperature sign (negative zero reports positive)
//    chk_err       last frame failed the checksum
//    range_err     last frame had a value above 9999
//    overrun       sticky, a frame arrived while busy
// -----------------------------------------------------------------------------
module am2302_bcd_decoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_valid,
   input  logic [39:0] frame_data,
   output logic        busy,
   output logic        result_valid,
   output logic [15:0] hum_bcd,
   output logic [15:0] temp_bcd,
   output logic        temp_neg,
   output logic        chk_err,
   output logic        range_err,
   output logic        overrun
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      CONV_H,
      CONV_T,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [39:0] frame_q, frame_d;
   logic [15:0] bcd_q, bcd_d;
   logic [15:0] bin_q, bin_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] hum_tmp_q, hum_tmp_d;
   logic [15:0] hum_bcd_q, hum_bcd_d;
   logic [15:0] temp_bcd_q, temp_bcd_d;
   logic        temp_neg_q, temp_neg_d;
   logic        chk_err_q, chk_err_d;
   logic        range_err_q, range_err_d;
   logic        overrun_q, overrun_d;
   logic        result_valid_q, result_valid_d;

   logic [7:0]  sum;
   logic [15:0] humidity;
   logic [15:0] tmag;
   logic [15:0] bcd_adj;
   logic [15:0] bcd_next;
   logic [15:0] bin_next;

   // Frame field decode plus one double-dabble step. Every BCD nibble that is
   // 5 or more gets 3 added, so that the following left shift carries
   // correctly into the next decimal digit. The binary MSB shifts into the
   // BCD LSB.
   always_comb begin
      sum      = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
      humidity = frame_q[39:24];
      tmag     = {1'b0, frame_q[22:8]};
      bcd_adj  = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      {bcd_next, bin_next} = {bcd_adj, bin_q} << 1;
   end

   // Next-state and next-output logic. Error frames never touch the digit
   // outputs, so a display keeps showing the last good reading. On a good
   // frame the humidity result is parked in hum_tmp until the temperature
   // finishes, so that both digit words change on the same edge.
   always_comb begin
      state_d        = state_q;
      frame_d        = frame_q;
      bcd_d          = bcd_q;
      bin_d          = bin_q;
      cnt_d          = cnt_q;
      hum_tmp_d      = hum_tmp_q;
      hum_bcd_d      = hum_bcd_q;
      temp_bcd_d     = temp_bcd_q;
      temp_neg_d     = temp_neg_q;
      chk_err_d      = chk_err_q;
      range_err_d    = range_err_q;
      overrun_d      = overrun_q;
      result_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_valid) begin
               frame_d   = frame_data;
               overrun_d = 1'b0;
               state_d   = CHECK;
            end
         end

         CHECK: begin
            if (sum != frame_q[7:0]) begin
               chk_err_d   = 1'b1;
               range_err_d = 1'b0;
               state_d     = DONE;
            end else if ((humidity > 16'd9999) || (tmag > 16'd9999)) begin
               chk_err_d   = 1'b0;
               range_err_d = 1'b1;
               state_d     = DONE;
            end else begin
               chk_err_d   = 1'b0;
               range_err_d = 1'b0;
               bcd_d       = 16'd0;
               bin_d       = humidity;
               cnt_d       = 4'd0;
               state_d     = CONV_H;
            end
         end

         CONV_H: begin
            bcd_d = bcd_next;
            bin_d = bin_next;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               hum_tmp_d = bcd_next;
               bcd_d     = 16'd0;
               bin_d     = tmag;
               cnt_d     = 4'd0;
               state_d   = CONV_T;
            end
         end

         CONV_T: begin
            bcd_d = bcd_next;
            bin_d = bin_next;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               hum_bcd_d  = hum_tmp_q;
               temp_bcd_d = bcd_next;
               temp_neg_d = frame_q[23] & (tmag != 16'd0);
               cnt_d      = 4'd0;
               state_d    = DONE;
            end
         end

         DONE: begin
            result_valid_d = 1'b1;
            state_d        = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // A strobe that cannot be accepted is dropped. It only leaves a trace.
      if (frame_valid && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   // State register. Reset returns everything, outputs included, to zero, so
   // an aborted conversion never produces a result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         frame_q        <= '0;
         bcd_q          <= '0;
         bin_q          <= '0;
         cnt_q          <= '0;
         hum_tmp_q      <= '0;
         hum_bcd_q      <= '0;
         temp_bcd_q     <= '0;
         temp_neg_q     <= 1'b0;
         chk_err_q      <= 1'b0;
         range_err_q    <= 1'b0;
         overrun_q      <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         frame_q        <= frame_d;
         bcd_q          <= bcd_d;
         bin_q          <= bin_d;
         cnt_q          <= cnt_d;
         hum_tmp_q      <= hum_tmp_d;
         hum_bcd_q      <= hum_bcd_d;
         temp_bcd_q     <= temp_bcd_d;
         temp_neg_q     <= temp_neg_d;
         chk_err_q      <= chk_err_d;
         range_err_q    <= range_err_d;
         overrun_q      <= overrun_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign busy         = (state_q != IDLE);
   assign result_valid = result_valid_q;
   assign hum_bcd      = hum_bcd_q;
   assign temp_bcd     = temp_bcd_q;
   assign temp_neg     = temp_neg_q;
   assign chk_err      = chk_err_q;
   assign range_err    = range_err_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_am2302_bcd_decoder.sv
// -----------------------------------------------------------------------------
// tb_am2302_bcd_decoder
//
// Purpose:
//    Self-checking bench for am2302_bcd_decoder. It runs directed frames and
//    randomized frames, and compares each result against a decimal reference
//    model that uses integer division.
// -----------------------------------------------------------------------------
module tb_am2302_bcd_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_valid;
   logic [39:0] frame_data;
   logic        busy;
   logic        result_valid;
   logic [15:0] hum_bcd;
   logic [15:0] temp_bcd;
   logic        temp_neg;
   logic        chk_err;
   logic        range_err;
   logic        overrun;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [15:0] expHum   = 16'h0;
   logic [15:0] expTemp  = 16'h0;
   logic        expNeg   = 1'b0;
   logic        expChk   = 1'b0;
   logic        expRange = 1'b0;
   int          expLat   = 0;

   am2302_bcd_decoder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_valid  (frame_valid),
      .frame_data   (frame_data),
      .busy         (busy),
      .result_valid (result_valid),
      .hum_bcd      (hum_bcd),
      .temp_bcd     (temp_bcd),
      .temp_neg     (temp_neg),
      .chk_err      (chk_err),
      .range_err    (range_err),
      .overrun      (overrun)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Single comparison point. Every check is counted here, and any mismatch
   // is reported here.
   task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Decimal value to packed BCD, computed digit by digit with division.
   function automatic logic [15:0] toBcd(input int v);
      return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   // Reference model. It predicts status, digits and latency for an accepted
   // frame. The digit fields are left alone on error frames.
   task automatic modelFrame(input logic [39:0] f);
      int b4, b3, b2, b1, b0, hum, tmag;
      b4   = int'(f[39:32]);
      b3   = int'(f[31:24]);
      b2   = int'(f[23:16]);
      b1   = int'(f[15:8]);
      b0   = int'(f[7:0]);
      hum  = b4 * 256 + b3;
      tmag = (b2 % 128) * 256 + b1;
      if (((b4 + b3 + b2 + b1) % 256) != b0) begin
         expChk = 1'b1; expRange = 1'b0; expLat = 2;
      end else if (hum > 9999 || tmag > 9999) begin
         expChk = 1'b0; expRange = 1'b1; expLat = 2;
      end else begin
         expChk   = 1'b0;
         expRange = 1'b0;
         expHum   = toBcd(hum);
         expTemp  = toBcd(tmag);
         expNeg   = (b2 >= 128) && (tmag != 0);
         expLat   = 34;
      end
   endtask

   // Builds a frame from field values. When asked, it corrupts the checksum
   // by a nonzero amount.
   function automatic logic [39:0] makeFrame(input int hum, input int tmag, input bit neg, input bit corrupt);
      logic [39:0] f;
      int          s;
      f[39:24] = 16'(hum);
      f[23]    = neg;
      f[22:8]  = 15'(tmag);
      s        = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
      if (corrupt) s = s + int'($urandom_range(1, 255));
      f[7:0]   = 8'(s);
      return f;
   endfunction

   // Presents a one-cycle strobe. It returns 1 time unit after the edge that
   // samples the strobe (E0).
   task automatic driveFrame(input logic [39:0] f);
      @(negedge clk);
      frame_valid = 1'b1;
      frame_data  = f;
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
   endtask

   // Counts edges until result_valid appears. A value of -1 means the
   // cycle budget ran out.
   task automatic waitResult(output int lat);
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (result_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   // Compares the status and digit outputs against the model.
   task automatic checkFields(input string tag);
      checkOutput({tag, "_hum"},   hum_bcd,   expHum);
      checkOutput({tag, "_temp"},  temp_bcd,  expTemp);
      checkOutput({tag, "_neg"},   temp_neg,  expNeg);
      checkOutput({tag, "_chk"},   chk_err,   expChk);
      checkOutput({tag, "_range"}, range_err, expRange);
   endtask

   // One full transaction: model, drive, then wait and check everything,
   // including a one-cycle result pulse and a cleared overrun.
   task automatic applyStimulus(input string tag, input logic [39:0] f);
      int lat;
      modelFrame(f);
      driveFrame(f);
      checkOutput({tag, "_busy"}, busy, 1'b1);
      waitResult(lat);
      checkOutput({tag, "_latency"}, 40'(lat), 40'(expLat));
      checkFields(tag);
      checkOutput({tag, "_overrun"}, overrun, 1'b0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_pulse"}, result_valid, 1'b0);
   endtask

   // Main sequence: reset, test-plan frames, overrun and DONE-cycle
   // boundaries, randomized frames, and finally a reset mid-conversion.
   initial begin
      int lat;
      int pulses;
      rst_n       = 1'b0;
      frame_valid = 1'b0;
      frame_data  = '0;
      #23;
      checkOutput("reset_busy",    busy,         1'b0);
      checkOutput("reset_rv",      result_valid, 1'b0);
      checkOutput("reset_hum",     hum_bcd,      16'h0);
      checkOutput("reset_temp",    temp_bcd,     16'h0);
      checkOutput("reset_overrun", overrun,      1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("good",    40'h028C015FEE);
      checkOutput("good_hum_const", hum_bcd, 16'h0652);
      checkOutput("good_temp_const", temp_bcd, 16'h0351);
      applyStimulus("negtemp", 40'h028C806573);
      applyStimulus("negzero", 40'h01F4800075);
      applyStimulus("good2",   40'h028C015FEE);
      applyStimulus("badchk",  40'h028C015FEF);
      checkOutput("badchk_hum_held", hum_bcd, 16'h0652);
      applyStimulus("range",   40'h2710000037);
      checkOutput("range_temp_held", temp_bcd, 16'h0351);

      // Second strobe 10 cycles into a conversion. It must be ignored.
      modelFrame(40'h028C806573);
      driveFrame(40'h028C806573);
      repeat (9) @(posedge clk);
      driveFrame(40'h01F4800075);
      waitResult(lat);
      checkOutput("ovr_latency", 40'(lat + 10), 40'd34);
      checkFields("ovr");
      checkOutput("ovr_set", overrun, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus("ovr_clear", 40'h01F4800075);

      // A strobe in the DONE cycle is dropped. The next cycle is accepted.
      modelFrame(40'h028C806573);
      driveFrame(40'h028C806573);
      repeat (33) @(posedge clk);
      driveFrame(40'h028C015FEE);
      checkOutput("done_rv", result_valid, 1'b1);
      checkFields("done");
      checkOutput("done_overrun", overrun, 1'b1);
      applyStimulus("after_done", 40'h028C015FEE);

      // Randomized frames, including out-of-range and corrupted ones.
      for (int n = 0; n < 24; n++) begin
         int  h, t;
         bit  neg, bad;
         h   = int'($urandom_range(0, 10300));
         t   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 10300));
         neg = 1'($urandom_range(0, 1));
         bad = ($urandom_range(0, 3) == 0);
         applyStimulus($sformatf("rand%0d", n), makeFrame(h, t, neg, bad));
      end

      // Reset in the middle of a conversion. Afterwards, no result may appear.
      driveFrame(40'h028C015FEE);
      repeat (19) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_busy",    busy,         1'b0);
      checkOutput("rst_rv",      result_valid, 1'b0);
      checkOutput("rst_hum",     hum_bcd,      16'h0);
      checkOutput("rst_temp",    temp_bcd,     16'h0);
      checkOutput("rst_neg",     temp_neg,     1'b0);
      checkOutput("rst_chk",     chk_err,      1'b0);
      checkOutput("rst_range",   range_err,    1'b0);
      checkOutput("rst_overrun", overrun,      1'b0);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (result_valid) pulses++;
      end
      checkOutput("rst_no_result", 40'(pulses), 40'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
